// File: rtl/seg_scan_blink.sv
// seg_scan_blink: multiplexed 7-segment digit scanner with per-digit blanking,
// frame-coherent input snapshot, frame-synchronous cursor blink and
// anti-ghosting dead time at the start of every digit slot.
// Optional build macro: LEAD_ZERO_BLANK_EN (leading-zero suppression).
module seg_scan_blink #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEAD_CYC     = 2,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = DIGIT_W'(4'hA),
    localparam int unsigned CW = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_i,
    input  logic [CW-1:0]                 cursor_i,
    input  logic                          cursor_en_i,
    input  logic [NUM_DIGITS-1:0]         blank_mask_i,
    output logic [DIGIT_W-1:0]            code_o,
    output logic [NUM_DIGITS-1:0]         sel_n_o,
    output logic [CW-1:0]                 idx_o,
    output logic                          frame_o
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = $clog2(BLINK_FRAMES);
    localparam int unsigned DW = NUM_DIGITS * DIGIT_W;

    logic [PW-1:0]         presc_q, presc_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  started_q, started_d;
    logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
    logic [DIGIT_W-1:0]    code_q, code_d;
    logic                  frame_q, frame_d;
    logic [BW-1:0]         blink_q, blink_d;
    logic [DW-1:0]         sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0] sh_mask_q, sh_mask_d;
    logic [CW-1:0]         sh_cursor_q, sh_cursor_d;
    logic                  sh_cen_q, sh_cen_d;

    logic                  tick;
    logic                  frame_start;
    logic [DW-1:0]         src_digits;
    logic [NUM_DIGITS-1:0] src_mask;
    logic [CW-1:0]         src_cursor;
    logic                  src_cen;
    logic                  visible;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [DIGIT_W-1:0]    cur_digit;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] onehot_new;
    logic [NUM_DIGITS-1:0] onehot_cur;
`ifdef LEAD_ZERO_BLANK_EN
    logic                  lz_chain;
`endif

    // Next-state: prescaler, slot index, snapshot, blink phase and outputs
    always_comb begin
        presc_d     = presc_q;
        idx_d       = idx_q;
        started_d   = started_q;
        sel_n_d     = sel_n_q;
        code_d      = code_q;
        frame_d     = 1'b0;
        blink_d     = blink_q;
        sh_digits_d = sh_digits_q;
        sh_mask_d   = sh_mask_q;
        sh_cursor_d = sh_cursor_q;
        sh_cen_d    = sh_cen_q;
        cur_digit   = '0;
        cur_blank   = 1'b0;
        onehot_new  = '0;
        onehot_cur  = '0;

        tick        = (presc_q == PW'(SCAN_DIV - 1));
        frame_start = tick && (idx_q == CW'(NUM_DIGITS - 1));

        presc_d   = tick ? '0 : presc_q + PW'(1);
        started_d = started_q | tick;
        frame_d   = frame_start;
        if (tick) begin
            idx_d = (idx_q == CW'(NUM_DIGITS - 1)) ? '0 : idx_q + CW'(1);
        end

        // Frame start bypasses the snapshot so digit 0 already sees new inputs
        src_digits = frame_start ? digits_i     : sh_digits_q;
        src_mask   = frame_start ? blank_mask_i : sh_mask_q;
        src_cursor = frame_start ? cursor_i     : sh_cursor_q;
        src_cen    = frame_start ? cursor_en_i  : sh_cen_q;

        sh_digits_d = src_digits;
        sh_mask_d   = src_mask;
        sh_cursor_d = src_cursor;
        sh_cen_d    = src_cen;

        // A moved cursor restarts the blink so it is visible straight away
        if (frame_start) begin
            if (cursor_i != sh_cursor_q) begin
                blink_d = '0;
            end else if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                blink_d = '0;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
        visible = (blink_d < BW'(BLINK_FRAMES / 2));

        blank_vec = src_mask;
`ifdef LEAD_ZERO_BLANK_EN
        // Blank zeros from the top down until a nonzero digit or the cursor
        lz_chain = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            if (src_cen && (src_cursor == CW'(k))) begin
                lz_chain = 1'b0;
            end else if (lz_chain && (src_digits[k*DIGIT_W +: DIGIT_W] == '0)) begin
                blank_vec[k] = 1'b1;
            end else begin
                lz_chain = 1'b0;
            end
        end
`endif

        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_d == CW'(k)) begin
                cur_digit     = src_digits[k*DIGIT_W +: DIGIT_W];
                cur_blank     = blank_vec[k] |
                                (src_cen && (src_cursor == CW'(k)) && !visible);
                onehot_new[k] = 1'b1;
            end
            if (idx_q == CW'(k)) begin
                onehot_cur[k] = 1'b1;
            end
        end

        if (tick) begin
            code_d = cur_blank ? BLANK_CODE : cur_digit;
        end

        // Selects stay off for the dead window, then light the current digit
        if (tick) begin
            sel_n_d = (DEAD_CYC == 0) ? ~onehot_new : '1;
        end else if (started_q && (presc_d == PW'(DEAD_CYC))) begin
            sel_n_d = ~onehot_cur;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= CW'(NUM_DIGITS - 1);
            started_q   <= 1'b0;
            sel_n_q     <= '1;
            code_q      <= BLANK_CODE;
            frame_q     <= 1'b0;
            blink_q     <= '0;
            sh_digits_q <= '0;
            sh_mask_q   <= '0;
            sh_cursor_q <= '0;
            sh_cen_q    <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            sel_n_q     <= sel_n_d;
            code_q      <= code_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
            sh_digits_q <= sh_digits_d;
            sh_mask_q   <= sh_mask_d;
            sh_cursor_q <= sh_cursor_d;
            sh_cen_q    <= sh_cen_d;
        end
    end

    assign code_o  = code_q;
    assign sel_n_o = sel_n_q;
    assign idx_o   = idx_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_blink.sv
// Directed bench for seg_scan_blink: 4-digit instance for scan, snapshot,
// blink, mask and reset behaviour; 5-digit instance for an out-of-range cursor.
module tb_seg_scan_blink;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic        cen;
    logic [3:0]  mask;
    logic [3:0]  code;
    logic [3:0]  sel_n;
    logic [1:0]  idx;
    logic        frame;

    logic [19:0] digits5;
    logic [2:0]  cursor5;
    logic        cen5;
    logic [4:0]  mask5;
    logic [3:0]  code5;
    logic [4:0]  sel_n5;
    logic [2:0]  idx5;
    logic        frame5;

    int n_checks;
    int n_pass;

    seg_scan_blink #(
        .NUM_DIGITS(4), .DIGIT_W(4), .SCAN_DIV(4), .DEAD_CYC(1),
        .BLINK_FRAMES(4), .BLANK_CODE(4'hA)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits), .cursor_i(cursor),
        .cursor_en_i(cen), .blank_mask_i(mask), .code_o(code),
        .sel_n_o(sel_n), .idx_o(idx), .frame_o(frame)
    );

    seg_scan_blink #(
        .NUM_DIGITS(5), .DIGIT_W(4), .SCAN_DIV(4), .DEAD_CYC(1),
        .BLINK_FRAMES(4), .BLANK_CODE(4'hA)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .digits_i(digits5), .cursor_i(cursor5),
        .cursor_en_i(cen5), .blank_mask_i(mask5), .code_o(code5),
        .sel_n_o(sel_n5), .idx_o(idx5), .frame_o(frame5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Entered #1 after a slot's tick edge; leaves #1 after the next tick edge
    task automatic slot(input logic [1:0] exp_idx, input logic [3:0] exp_code);
        logic [3:0] exp_sel;
        exp_sel = ~(4'b0001 << exp_idx);
        check("idx", 32'(idx), 32'(exp_idx));
        check("code", 32'(code), 32'(exp_code));
        check("frame", 32'(frame), 32'(exp_idx == 2'd0));
        check("dead_sel", 32'(sel_n), 32'hF);
        @(posedge clk); #1;
        check("sel", 32'(sel_n), 32'(exp_sel));
        check("frame_end", 32'(frame), 32'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input logic [3:0] c3);
        slot(2'd0, c0);
        slot(2'd1, c1);
        slot(2'd2, c2);
        slot(2'd3, c3);
    endtask

    // Three quiet cycles after reset release, then land on slot 0
    task automatic after_reset();
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check("rel_sel", 32'(sel_n), 32'hF);
            check("rel_code", 32'(code), 32'hA);
            check("rel_frame", 32'(frame), 32'h0);
            check("rel_idx", 32'(idx), 32'h3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] exp5;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        digits   = 16'h4321;
        cursor   = 2'd0;
        cen      = 1'b0;
        mask     = 4'b0000;
        digits5  = 20'h54321;
        cursor5  = 3'd7;
        cen5     = 1'b1;
        mask5    = 5'b00000;

        #12;
        check("rst_sel", 32'(sel_n), 32'hF);
        check("rst_code", 32'(code), 32'hA);
        check("rst_idx", 32'(idx), 32'h3);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_sel5", 32'(sel_n5), 32'h1F);
        check("rst_idx5", 32'(idx5), 32'h4);

        // Scenario 1 and 2: release and plain scan
        @(negedge clk);
        rst_n = 1'b1;
        after_reset();
        run_frame(4'h1, 4'h2, 4'h3, 4'h4);

        // Scenario 3: mid-frame change waits for the next frame
        slot(2'd0, 4'h1);
        slot(2'd1, 4'h2);
        digits = 16'h8765;
        slot(2'd2, 4'h3);
        slot(2'd3, 4'h4);
        run_frame(4'h5, 4'h6, 4'h7, 4'h8);

        // Scenario 4: cursor on digit 2 blinks 2 frames on, 2 frames off
        digits = 16'h4321;
        cen    = 1'b1;
        cursor = 2'd2;
        run_frame(4'h5, 4'h6, 4'h7, 4'h8);
        run_frame(4'h1, 4'h2, 4'h3, 4'h4);
        run_frame(4'h1, 4'h2, 4'h3, 4'h4);
        run_frame(4'h1, 4'h2, 4'hA, 4'h4);
        slot(2'd0, 4'h1);
        cursor = 2'd1;
        slot(2'd1, 4'h2);
        slot(2'd2, 4'hA);
        slot(2'd3, 4'h4);
        // Moved cursor restarts visible; old cursor digit now steady
        run_frame(4'h1, 4'h2, 4'h3, 4'h4);
        run_frame(4'h1, 4'h2, 4'h3, 4'h4);
        run_frame(4'h1, 4'hA, 4'h3, 4'h4);
        run_frame(4'h1, 4'hA, 4'h3, 4'h4);

        // Scenario 5: masked digit that is also the cursor stays blank
        mask   = 4'b1000;
        cursor = 2'd3;
        run_frame(4'h1, 4'h2, 4'h3, 4'h4);
        run_frame(4'h1, 4'h2, 4'h3, 4'hA);
        run_frame(4'h1, 4'h2, 4'h3, 4'hA);
        run_frame(4'h1, 4'h2, 4'h3, 4'hA);
        run_frame(4'h1, 4'h2, 4'h3, 4'hA);

        // Scenario 6: asynchronous reset in the middle of slot 2
        slot(2'd0, 4'h1);
        slot(2'd1, 4'h2);
        @(posedge clk); #1;
        check("pre_rst_sel", 32'(sel_n), 32'hB);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel_n), 32'hF);
        check("arst_code", 32'(code), 32'hA);
        check("arst_idx", 32'(idx), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        after_reset();
        run_frame(4'h1, 4'h2, 4'h3, 4'hA);

        // Out-of-range cursor on the 5-digit instance never blinks
        repeat (80) begin
            @(posedge clk); #1;
            exp5 = 4'(idx5) + 4'd1;
            check("d5_code", 32'(code5), 32'(exp5));
        end

        // Leading-zero handling (suppressed only when the feature is built)
        digits = 16'h0050;
        mask   = 4'b0000;
        cen    = 1'b0;
        run_frame(4'h1, 4'h2, 4'h3, 4'hA);
`ifdef LEAD_ZERO_BLANK_EN
        run_frame(4'h0, 4'h5, 4'hA, 4'hA);
`else
        run_frame(4'h0, 4'h5, 4'h0, 4'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
